uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter that generalises the fixed 8N1 transmitter. Data width, parity mode and stop-bit count are set by parameters. The baud divisor is a runtime input. A one-entry holding buffer with a ready/valid handshake allows back-to-back frames with no idle gap. It sits between control logic (e.g. CAT/status reporting) and the serial TX pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
CNT_W, 16, width of the divisor input and the bit-period counter

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous reset, active-high
i_Clks_Per_Bit  in  CNT_W  clocks per bit (divisor); sampled at each frame start
i_Tx_DV  in  1  data valid; a word is accepted when i_Tx_DV && o_Tx_Ready at a rising edge
i_Tx_Byte  in  DATA_BITS  word to send
o_Tx_Ready  out  1  holding buffer empty; registered
o_Tx_Active  out  1  high while a frame (start..last stop bit) is on the line
o_Tx_Serial  out  1  serial line; idle high
o_Tx_Done  out  1  one-cycle pulse after each frame's final stop bit

Behaviour:
- Reset values, applied one cycle after i_Reset is sampled high:
  - o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0, o_Tx_Done = 0
  - holding buffer empty, FSM in IDLE, counters 0
- Reset mid-frame:
  - Line returns high on the next edge.
  - The frame is aborted, the buffered word is discarded, and no Done pulse is issued.
- Holding buffer:
  - Loads i_Tx_Byte on accept; o_Tx_Ready = !hold_valid.
  - Drains into the shift register when the FSM is in IDLE, or on the last cycle of the final stop bit.
  - Accept and drain cannot coincide, because accept requires the buffer to be empty.
- Divisor:
  - D = i_Clks_Per_Bit, latched at frame load. Changes mid-frame have no effect.
  - D < 2 is treated as 2.
  - Every bit, including parity and stop bits, lasts exactly D cycles.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START when the buffer is full.
  - IDLE: line high. If hold_valid, load the shift register and D, clear hold_valid, go to START.
  - START: line 0 for D cycles.
  - DATA: shift register bit[i] for D cycles each, i = 0..DATA_BITS-1. The bit index wraps to 0 on leaving DATA.
  - PARITY (skipped when PARITY = 0):
    - odd: bit = ~^data
    - even: bit = ^data
    - Computed from the latched word.
  - STOP: line 1 for STOP_BITS*D cycles.
  - On the last STOP cycle:
    - If hold_valid: load the next word and go directly to START, so the next start bit follows immediately with no idle cycle.
    - Otherwise go to IDLE.
- Latency: a word accepted at edge k into an idle block drives o_Tx_Serial low from edge k+2. (Edge k+1 performs the load; the start bit is registered at k+2.)
- o_Tx_Active:
  - Rises with the start bit.
  - Falls after the last stop cycle unless a back-to-back frame follows, in which case it stays high continuously.
- o_Tx_Done:
  - Asserted for exactly 1 cycle in the cycle after the final stop bit completes.
  - Also pulses on back-to-back frames, once per frame.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * D cycles.

Test Plan:
- Reset then idle, DATA_BITS=8, PARITY=0, STOP_BITS=1, D=4: send 0xA5 -> line 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. Frame = 40 cycles; o_Tx_Done pulses once; o_Tx_Active high exactly 40 cycles.
- PARITY=2, send 0x55 -> parity bit 0. PARITY=1, send 0x55 -> parity bit 1. PARITY=1, send 0x54 -> parity bit 0. Frame = 44 cycles at D=4.
- Back-to-back: offer 0x01 and 0x02 as soon as o_Tx_Ready allows -> second start bit begins on the cycle after the first stop bit ends. o_Tx_Active never drops; two Done pulses 40 cycles apart; o_Tx_Ready low while the buffer is full.
- DATA_BITS=7, STOP_BITS=2, D=1 (treated as 2), send 0x7F -> 7 ones, stop held 4 cycles, frame = 20 cycles. Changing i_Clks_Per_Bit to 10 mid-frame does not alter the timing.
- Assert i_Reset for 1 cycle during DATA with the buffer full -> next edge: o_Tx_Serial = 1, o_Tx_Ready = 1, o_Tx_Active = 0. No Done pulse; buffered word never transmitted.
- Hold i_Tx_DV high with o_Tx_Ready = 0 for 20 cycles -> no word accepted and the transmitted data is unchanged.

Source files
------------

// File: rtl/uart_tx_frame.sv
`timescale 1ns/1ps
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// runtime baud divisor, and a one-entry holding buffer for gap-free back-to-back frames.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line high, waiting for the holding buffer to fill
// S_START  | start bit (0) for D cycles
// S_DATA   | data bits LSB first, D cycles each
// S_PARITY | parity bit for D cycles (never entered when PARITY = 0)
// S_STOP   | stop bits (1) for STOP_BITS*D cycles; chains to S_START if buffer full
module uart_tx_frame #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic [CNT_W-1:0]     i_Clks_Per_Bit,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_n;
    logic                 hold_valid, hold_valid_n;
    logic [DATA_BITS-1:0] hold_data, hold_data_n;
    logic [DATA_BITS-1:0] shift_data, shift_data_n;
    logic [CNT_W-1:0]     div_q, div_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic                 stop_idx, stop_idx_n;
    logic                 serial_q, serial_n;
    logic                 active_q, active_n;
    logic                 stop_end_q, stop_end_n;
    logic                 done_q;

    logic                 accept;
    logic                 bit_end;
    logic                 last_stop;
    logic                 load;
    logic                 parity_bit;
    logic [CNT_W-1:0]     div_in;

    assign accept     = i_Tx_DV && !hold_valid;
    assign div_in     = (i_Clks_Per_Bit < CNT_W'(2)) ? CNT_W'(2) : i_Clks_Per_Bit;
    assign bit_end    = (cnt == '0);
    assign last_stop  = (state == S_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    assign parity_bit = (PARITY == 1) ? ~^shift_data : ^shift_data;

    always_comb begin
        state_n      = state;
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        shift_data_n = shift_data;
        div_n        = div_q;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        stop_idx_n   = stop_idx;
        load         = 1'b0;
        serial_n     = 1'b1;
        active_n     = (state != S_IDLE);
        stop_end_n   = last_stop;

        if (accept) begin
            hold_valid_n = 1'b1;
            hold_data_n  = i_Tx_Byte;
        end

        // Down-counter: each bit ends on terminal count, then reloads D-1.
        if (state != S_IDLE) begin
            if (bit_end) begin
                cnt_n = div_q - CNT_W'(1);
            end else begin
                cnt_n = cnt - CNT_W'(1);
            end
        end

        case (state)
            S_IDLE: begin
                if (hold_valid) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                serial_n = 1'b0;
                if (bit_end) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                serial_n = shift_data[bit_idx];
                if (bit_end) begin
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                serial_n = parity_bit;
                if (bit_end) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    if (last_stop) begin
                        stop_idx_n = 1'b0;
                        if (hold_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        stop_idx_n = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Load never coincides with accept: accept needs the buffer empty, load needs it full.
        if (load) begin
            shift_data_n = hold_data;
            div_n        = div_in;
            cnt_n        = div_in - CNT_W'(1);
            hold_valid_n = 1'b0;
            bit_idx_n    = '0;
            stop_idx_n   = 1'b0;
            state_n      = S_START;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state      <= S_IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shift_data <= '0;
            div_q      <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            stop_end_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            hold_valid <= hold_valid_n;
            hold_data  <= hold_data_n;
            shift_data <= shift_data_n;
            div_q      <= div_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            stop_idx   <= stop_idx_n;
            serial_q   <= serial_n;
            active_q   <= active_n;
            stop_end_q <= stop_end_n;
            done_q     <= stop_end_q;
        end
    end

    assign o_Tx_Ready  = ~hold_valid;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

endmodule
